// File: rtl/led_position_tracker.sv
// One-hot area position tracker for an N_LED bar with a sticky DONE state (whole bar lit).
// Define LED_BLINK_EN to make the bar blink in DONE, with BLINK_DIV cycles per half-period.
module led_position_tracker #(
  parameter int N_LED     = 8,
  parameter int AREA_W    = $clog2(N_LED),
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              finish,
  input  logic              switch,
  input  logic [AREA_W-1:0] area,
  output logic [N_LED-1:0]  led,
  output logic [AREA_W-1:0] pos,
  output logic              done,
  output logic              changed,
  output logic              err
);

  if (N_LED < 2 || N_LED > 256 || AREA_W < 1 || BLINK_DIV < 1) begin : g_bad_params
    $error("led_position_tracker: illegal parameter set");
  end

  typedef enum logic {TRACK, DONE} state_t;

  state_t            state_q;
  logic [N_LED-1:0]  led_q;
  logic [AREA_W-1:0] pos_q;
  logic              done_q;
  logic              changed_q;
  logic              err_q;
  logic              area_ok;

  // Area 0 drives the MSB LED.
  function automatic logic [N_LED-1:0] onehot(input logic [AREA_W-1:0] a);
    logic [N_LED-1:0] v;
    v = '0;
    for (int i = 0; i < N_LED; i++) begin
      v[i] = (a == AREA_W'(N_LED - 1 - i));
    end
    return v;
  endfunction

  // One extra bit so the compare is also correct when N_LED == 2**AREA_W.
  assign area_ok = ({1'b0, area} < (AREA_W + 1)'(N_LED));

`ifdef LED_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV + 1);
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_on_q;
  logic             blink_wrap;
  assign blink_wrap = (blink_cnt_q == CNT_W'(BLINK_DIV - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TRACK;
      pos_q     <= '0;
      led_q     <= onehot('0);
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef LED_BLINK_EN
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
`endif
    end else begin
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        TRACK: begin
          if (finish) begin
            state_q <= DONE;
            led_q   <= '1;
            done_q  <= 1'b1;
          end else if (switch) begin
            if (!area_ok) begin
              err_q <= 1'b1;
            end else if (area != pos_q) begin
              pos_q     <= area;
              led_q     <= onehot(area);
              changed_q <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef LED_BLINK_EN
          if (blink_wrap) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
            led_q       <= blink_on_q ? '0 : '1;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
`endif
        end
      endcase
    end
  end

  assign led     = led_q;
  assign pos     = pos_q;
  assign done    = done_q;
  assign changed = changed_q;
  assign err     = err_q;

endmodule

// File: tb/tb_led_position_tracker.sv
// Bench for led_position_tracker: an 8-LED and a 6-LED instance driven in lockstep against a reference model.
module tb_led_position_tracker;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0, finish = 1'b0, switch = 1'b0;
  logic [2:0] area = '0;
  logic [7:0] led0;
  logic [5:0] led1;
  logic [2:0] pos0, pos1;
  logic       done0, done1, chg0, chg1, err0, err1;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, index 0 = 8 LEDs, index 1 = 6 LEDs.
  int nl[2]     = '{8, 6};
  int m_pos[2]  = '{0, 0};
  int m_dcnt[2] = '{0, 0};
  bit m_done[2] = '{0, 0};
  bit m_chg[2]  = '{0, 0};
  bit m_err[2]  = '{0, 0};

  always #5 clk = ~clk;

  led_position_tracker #(.N_LED(8), .BLINK_DIV(BDIV)) u_dut8 (
    .clk(clk), .reset(reset), .finish(finish), .switch(switch), .area(area),
    .led(led0), .pos(pos0), .done(done0), .changed(chg0), .err(err0));

  led_position_tracker #(.N_LED(6), .BLINK_DIV(BDIV)) u_dut6 (
    .clk(clk), .reset(reset), .finish(finish), .switch(switch), .area(area),
    .led(led1), .pos(pos1), .done(done1), .changed(chg1), .err(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_led(input int k);
    int ones;
    ones = (1 << nl[k]) - 1;
    if (!m_done[k]) return 1 << (nl[k] - 1 - m_pos[k]);
`ifdef LED_BLINK_EN
    return ((m_dcnt[k] / BDIV) % 2 == 0) ? ones : 0;
`else
    return ones;
`endif
  endfunction

  task automatic model_update(input bit r, input bit f, input bit s, input int a);
    for (int k = 0; k < 2; k++) begin
      m_chg[k] = 0;
      m_err[k] = 0;
      if (r) begin
        m_pos[k] = 0; m_done[k] = 0; m_dcnt[k] = 0;
      end else if (m_done[k]) begin
        m_dcnt[k]++;
      end else if (f) begin
        m_done[k] = 1; m_dcnt[k] = 0;
      end else if (s) begin
        if (a >= nl[k]) m_err[k] = 1;
        else if (a != m_pos[k]) begin
          m_pos[k] = a; m_chg[k] = 1;
        end
      end
    end
  endtask

  // Apply inputs for one edge, advance the model, then compare 1ns after the edge.
  task automatic tick(input bit r, input bit f, input bit s, input int a);
    reset = r; finish = f; switch = s; area = 3'(a);
    @(posedge clk);
    model_update(r, f, s, a);
    #1;
    check("led8",  32'(led0),  32'(exp_led(0)));
    check("pos8",  32'(pos0),  32'(m_pos[0]));
    check("done8", 32'(done0), 32'(m_done[0]));
    check("chg8",  32'(chg0),  32'(m_chg[0]));
    check("err8",  32'(err0),  32'(m_err[0]));
    check("led6",  32'(led1),  32'(exp_led(1)));
    check("pos6",  32'(pos1),  32'(m_pos[1]));
    check("done6", 32'(done1), 32'(m_done[1]));
    check("chg6",  32'(chg1),  32'(m_chg[1]));
    check("err6",  32'(err1),  32'(m_err[1]));
  endtask

  initial begin
    // Reset for two cycles.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("rst_led8", 32'(led0), 32'h80);
    check("rst_led6", 32'(led1), 32'h20);

    // Switch to area 3, then hold it.
    tick(0, 0, 1, 3);
    check("sw3_led8", 32'(led0), 32'h10);
    check("sw3_chg8", 32'(chg0), 32'h1);
    tick(0, 0, 1, 3);
    check("hold_chg8", 32'(chg0), 32'h0);
    tick(0, 0, 0, 5);

    // Area 6 is legal on 8 LEDs, out of range on 6.
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 6);
    check("oor_err6", 32'(err1), 32'h1);
    check("oor_led6", 32'(led1), 32'h20);
    tick(0, 0, 1, 7);
    tick(0, 0, 0, 0);
    check("oor_clr6", 32'(err1), 32'h0);

    // Random traffic with occasional finish and reset.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
    end

    // Finish beats a simultaneous switch, then DONE is sticky for 12 cycles.
    tick(1, 0, 0, 0);
    tick(0, 1, 1, 5);
    check("fin_led8", 32'(led0), 32'hFF);
    check("fin_pos8", 32'(pos0), 32'h0);
    for (int i = 0; i < 12; i++) tick(0, 0, 1, 2);
    check("done_pos8", 32'(pos0), 32'h0);

    // Reset from DONE (blink off phase when blinking), then area 7.
    tick(1, 0, 0, 0);
    check("rdone_led8", 32'(led0), 32'h80);
    check("rdone_done8", 32'(done0), 32'h0);
    tick(0, 0, 1, 7);
    check("a7_led8", 32'(led0), 32'h01);
    tick(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
